// File: rtl/jcu_seq.sv
// jcu_seq: self-sequencing control unit for the jcscpu datapath.
// It holds a 4-phase clock generator, a 6-step stepper and a halt latch.
// All outputs are decoded combinationally from ph/st/halt, ir_bus and the flags.
// Optional feature macro: JCU_IO_EN. When it is defined, the IO instruction
// (opcode 111) is decoded. When it is undefined, opcode 111 is a NOP and the
// io_* outputs are tied low.
module jcu_seq #(
    parameter  int REG_BITS = 2,
    localparam int NREGS    = 1 << REG_BITS,
    localparam int IW       = 4 + 2*REG_BITS
) (
    input  logic             CLK_clk,
    input  logic             RST_rst,
    input  logic [0:IW-1]    ir_bus,
    input  logic             flags_co,
    input  logic             flags_alo,
    input  logic             flags_eqo,
    input  logic             flags_z,
    output logic [0:2]       alu_op,
    output logic             alu_ena_ci,
    output logic             bus1_bit1,
    output logic             flags_s,
    output logic             tmp_s,
    output logic             acc_s,
    output logic             ram_mar_s,
    output logic             ram_s,
    output logic             iar_s,
    output logic             ir_s,
    output logic             acc_e,
    output logic             ram_e,
    output logic             iar_e,
    output logic [0:NREGS-1] reg_s,
    output logic [0:NREGS-1] reg_e,
    output logic             io_s,
    output logic             io_e,
    output logic             io_io,
    output logic             io_da,
    output logic             halt,
    output logic [0:5]       step
);
    localparam int OW = 2*REG_BITS;

    typedef enum logic [2:0] {
        ST0 = 3'd0, ST1 = 3'd1, ST2 = 3'd2, ST3 = 3'd3, ST4 = 3'd4, ST5 = 3'd5
    } st_t;

    st_t        st_q, st_d;
    logic [1:0] ph_q, ph_d;
    logic       halt_q, halt_d;

    // instruction fields; ir_bus bit 0 is the MSB
    logic [2:0]          opc;
    logic [REG_BITS-1:0] ra, rb;
    logic [OW-1:0]       opnd;
    logic                is_alu, is_cmp, is_clf, is_halt, taken;

    assign opc     = ir_bus[1:3];
    assign ra      = ir_bus[4:3+REG_BITS];
    assign rb      = ir_bus[4+REG_BITS:IW-1];
    assign opnd    = ir_bus[4:IW-1];
    assign is_alu  = ir_bus[0];
    assign is_cmp  = is_alu && (opc == 3'b111);
    assign is_clf  = !is_alu && (opc == 3'b110) && (opnd == '0);
    assign is_halt = !is_alu && (opc == 3'b110) && (opnd == OW'(1));
    assign taken   = |({ir_bus[4], ir_bus[5], ir_bus[6], ir_bus[7]} &
                       {flags_co, flags_alo, flags_eqo, flags_z});

    // per-step intents, before the phase windows are applied
    logic e_iar, e_ram, e_acc, e_ra, e_rb;
    logic s_flags, s_tmp, s_acc, s_mar, s_ram, s_iar, s_ir, s_rb;
    logic l_bit1, l_ci, l_aluop;
`ifdef JCU_IO_EN
    logic e_io, s_io, l_io;
`endif

    // phase windows; a latched halt silences everything
    logic en_w, set_w, lvl_w;
    assign en_w  = !halt_q && (ph_q != 2'd3);
    assign set_w = !halt_q && (ph_q == 2'd1);
    assign lvl_w = !halt_q;

    // stepper, phase counter and halt latch
    always_ff @(posedge CLK_clk) begin
        if (RST_rst) begin
            st_q   <= ST0;
            ph_q   <= 2'd0;
            halt_q <= 1'b0;
        end else begin
            st_q   <= st_d;
            ph_q   <= ph_d;
            halt_q <= halt_d;
        end
    end

    // advance ph, then st on ph wrap; HALT freezes the counters at st5 ph3
    always_comb begin
        st_d   = st_q;
        ph_d   = ph_q;
        halt_d = halt_q;
        if (!halt_q) begin
            if (ph_q == 2'd3) begin
                if (st_q == ST5 && is_halt) begin
                    halt_d = 1'b1;
                end else begin
                    ph_d = 2'd0;
                    case (st_q)
                        ST0:     st_d = ST1;
                        ST1:     st_d = ST2;
                        ST2:     st_d = ST3;
                        ST3:     st_d = ST4;
                        ST4:     st_d = ST5;
                        default: st_d = ST0;
                    endcase
                end
            end else begin
                ph_d = ph_q + 2'd1;
            end
        end
    end

    // instruction table: which strobes each step wants
    always_comb begin
        e_iar = 1'b0; e_ram = 1'b0; e_acc = 1'b0; e_ra = 1'b0; e_rb = 1'b0;
        s_flags = 1'b0; s_tmp = 1'b0; s_acc = 1'b0; s_mar = 1'b0;
        s_ram = 1'b0; s_iar = 1'b0; s_ir = 1'b0; s_rb = 1'b0;
        l_bit1 = 1'b0; l_ci = 1'b0; l_aluop = 1'b0;
`ifdef JCU_IO_EN
        e_io = 1'b0; s_io = 1'b0; l_io = 1'b0;
`endif
        case (st_q)
            ST0: begin l_bit1 = 1'b1; e_iar = 1'b1; s_mar = 1'b1; s_acc = 1'b1; end
            ST1: begin e_ram = 1'b1; s_ir = 1'b1; end
            ST2: begin e_acc = 1'b1; s_iar = 1'b1; end
            ST3: begin
                if (is_alu) begin
                    e_rb = 1'b1; s_tmp = 1'b1;
                end else begin
                    case (opc)
                        3'b000, 3'b001: begin e_ra = 1'b1; s_mar = 1'b1; end
                        3'b010, 3'b101: begin
                            l_bit1 = 1'b1; e_iar = 1'b1; s_mar = 1'b1; s_acc = 1'b1;
                        end
                        3'b011: begin e_rb = 1'b1; s_iar = 1'b1; end
                        3'b100: begin e_iar = 1'b1; s_mar = 1'b1; end
                        3'b110: begin
                            if (is_clf) begin l_bit1 = 1'b1; s_flags = 1'b1; end
                        end
                        default: begin
`ifdef JCU_IO_EN
                            l_io = 1'b1;
                            if (ir_bus[4]) begin e_rb = 1'b1; s_io = 1'b1; end
`endif
                        end
                    endcase
                end
            end
            ST4: begin
                if (is_alu) begin
                    e_ra = 1'b1; l_ci = 1'b1; l_aluop = 1'b1; s_acc = 1'b1; s_flags = 1'b1;
                end else begin
                    case (opc)
                        3'b000, 3'b010: begin e_ram = 1'b1; s_rb = 1'b1; end
                        3'b001:         begin e_rb = 1'b1; s_ram = 1'b1; end
                        3'b100:         begin e_ram = 1'b1; s_iar = 1'b1; end
                        3'b101:         begin e_acc = 1'b1; s_iar = 1'b1; end
                        3'b111: begin
`ifdef JCU_IO_EN
                            l_io = 1'b1;
                            if (!ir_bus[4]) begin e_io = 1'b1; s_rb = 1'b1; end
`endif
                        end
                        default: ;
                    endcase
                end
            end
            ST5: begin
                if (is_alu) begin
                    if (!is_cmp) begin e_acc = 1'b1; s_rb = 1'b1; end
                end else begin
                    case (opc)
                        3'b010: begin e_acc = 1'b1; s_iar = 1'b1; end
                        3'b101: begin
                            if (taken) begin e_ram = 1'b1; s_iar = 1'b1; end
                        end
                        3'b111: begin
`ifdef JCU_IO_EN
                            l_io = 1'b1;
`endif
                        end
                        default: ;
                    endcase
                end
            end
            default: ;
        endcase
    end

    // apply phase windows to the intents
    always_comb begin
        acc_e      = en_w & e_acc;
        ram_e      = en_w & e_ram;
        iar_e      = en_w & e_iar;
        flags_s    = set_w & s_flags;
        tmp_s      = set_w & s_tmp;
        acc_s      = set_w & s_acc;
        ram_mar_s  = set_w & s_mar;
        ram_s      = set_w & s_ram;
        iar_s      = set_w & s_iar;
        ir_s       = set_w & s_ir;
        bus1_bit1  = lvl_w & l_bit1;
        alu_ena_ci = lvl_w & l_ci;
        alu_op     = (lvl_w && l_aluop) ? ir_bus[1:3] : 3'b000;
        halt       = halt_q | (st_q == ST5 && is_halt);
    end

`ifdef JCU_IO_EN
    assign io_s  = set_w & s_io;
    assign io_e  = en_w & e_io;
    assign io_io = lvl_w & l_io & ir_bus[4];
    assign io_da = lvl_w & l_io & ir_bus[5];
`else
    assign io_s  = 1'b0;
    assign io_e  = 1'b0;
    assign io_io = 1'b0;
    assign io_da = 1'b0;
`endif

    // register selects; RA and RB hitting the same register merge into one bit
    for (genvar i = 0; i < NREGS; i++) begin : g_reg
        assign reg_e[i] = en_w && ((e_ra && ra == REG_BITS'(i)) || (e_rb && rb == REG_BITS'(i)));
        assign reg_s[i] = set_w && s_rb && (rb == REG_BITS'(i));
    end

    for (genvar i = 0; i < 6; i++) begin : g_step
        assign step[i] = (st_q == st_t'(i));
    end
endmodule

// File: tb/tb_jcu_seq.sv
// tb_jcu_seq: directed bench for jcu_seq. Expected per-cycle outputs are
// queued from step tables, then popped and compared each cycle.
module tb_jcu_seq;
    typedef logic [33:0] ov_t;

    // packed output layout (MSB..LSB)
    localparam ov_t CI    = 34'd1 << 30;
    localparam ov_t BIT1  = 34'd1 << 29;
    localparam ov_t FLG_S = 34'd1 << 28;
    localparam ov_t TMP_S = 34'd1 << 27;
    localparam ov_t ACC_S = 34'd1 << 26;
    localparam ov_t MAR_S = 34'd1 << 25;
    localparam ov_t RAM_S = 34'd1 << 24;
    localparam ov_t IAR_S = 34'd1 << 23;
    localparam ov_t IR_S  = 34'd1 << 22;
    localparam ov_t ACC_E = 34'd1 << 21;
    localparam ov_t RAM_E = 34'd1 << 20;
    localparam ov_t IAR_E = 34'd1 << 19;
    localparam ov_t IO_S  = 34'd1 << 10;
    localparam ov_t IO_E  = 34'd1 << 9;
    localparam ov_t IO_IO = 34'd1 << 8;
    localparam ov_t IO_DA = 34'd1 << 7;
    localparam ov_t HALT  = 34'd1 << 6;
    localparam ov_t REGM  = 34'hFF << 11;

    function automatic ov_t RE(input logic [3:0] m); return ov_t'(m) << 11; endfunction
    function automatic ov_t RS(input logic [3:0] m); return ov_t'(m) << 15; endfunction
    function automatic ov_t OP(input logic [2:0] m); return ov_t'(m) << 31; endfunction

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [0:7] ir2 = '0;
    logic [0:9] ir3 = 10'b0000_101_011;
    logic co = 1'b0, alo = 1'b0, eqo = 1'b0, z = 1'b0;

    logic [0:2] alu_op2, alu_op3;
    logic ci2, b12, fs2, ts2, as2, ms2, rs2, is2, irs2, ae2, re2, ie2, ios2, ioe2, iio2, ida2, h2;
    logic ci3, b13, fs3, ts3, as3, ms3, rs3, is3, irs3, ae3, re3, ie3, ios3, ioe3, iio3, ida3, h3;
    logic [0:3] regs2, rege2;
    logic [0:7] regs3, rege3;
    logic [0:5] step2, step3;

    jcu_seq #(.REG_BITS(2)) u2 (
        .CLK_clk(clk), .RST_rst(rst), .ir_bus(ir2),
        .flags_co(co), .flags_alo(alo), .flags_eqo(eqo), .flags_z(z),
        .alu_op(alu_op2), .alu_ena_ci(ci2), .bus1_bit1(b12), .flags_s(fs2), .tmp_s(ts2),
        .acc_s(as2), .ram_mar_s(ms2), .ram_s(rs2), .iar_s(is2), .ir_s(irs2),
        .acc_e(ae2), .ram_e(re2), .iar_e(ie2), .reg_s(regs2), .reg_e(rege2),
        .io_s(ios2), .io_e(ioe2), .io_io(iio2), .io_da(ida2), .halt(h2), .step(step2)
    );

    jcu_seq #(.REG_BITS(3)) u3 (
        .CLK_clk(clk), .RST_rst(rst), .ir_bus(ir3),
        .flags_co(co), .flags_alo(alo), .flags_eqo(eqo), .flags_z(z),
        .alu_op(alu_op3), .alu_ena_ci(ci3), .bus1_bit1(b13), .flags_s(fs3), .tmp_s(ts3),
        .acc_s(as3), .ram_mar_s(ms3), .ram_s(rs3), .iar_s(is3), .ir_s(irs3),
        .acc_e(ae3), .ram_e(re3), .iar_e(ie3), .reg_s(regs3), .reg_e(rege3),
        .io_s(ios3), .io_e(ioe3), .io_io(iio3), .io_da(ida3), .halt(h3), .step(step3)
    );

    ov_t obs2, obs3;
    logic [15:0] regs3_obs;
    assign obs2 = {alu_op2, ci2, b12, fs2, ts2, as2, ms2, rs2, is2, irs2, ae2, re2, ie2,
                   regs2, rege2, ios2, ioe2, iio2, ida2, h2, step2};
    assign obs3 = {alu_op3, ci3, b13, fs3, ts3, as3, ms3, rs3, is3, irs3, ae3, re3, ie3,
                   8'h00, ios3, ioe3, iio3, ida3, h3, step3};
    assign regs3_obs = {regs3, rege3};

    always #5 clk = ~clk;

    ov_t         exp_q[$];
    logic [15:0] q3[$];
    int          passed = 0;
    int          total  = 0;

    task automatic check(input string tag, input int cyc, input ov_t got, input ov_t want);
        total++;
        assert (got === want) passed++;
        else $error("FAIL %s cyc %0d got %h want %h", tag, cyc, got, want);
    endtask

    // expand one step: en in ph0..2, se in ph1, lv in all four phases
    task automatic exp_step(input int s, input ov_t en, input ov_t se, input ov_t lv);
        for (int ph = 0; ph < 4; ph++) begin
            ov_t v;
            v = lv | ov_t'(6'b100000 >> s);
            if (ph < 3)  v |= en;
            if (ph == 1) v |= se;
            exp_q.push_back(v);
        end
    endtask

    task automatic exp_fetch();
        exp_step(0, IAR_E, MAR_S | ACC_S, BIT1);
        exp_step(1, RAM_E, IR_S, '0);
        exp_step(2, ACC_E, IAR_S, '0);
    endtask

    // reset pulse, then compare every queued cycle
    task automatic run(input string tag, input logic [7:0] ir, input logic [3:0] fl, input bit do3);
        ir2 = ir;
        {co, alo, eqo, z} = fl;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int cyc = 0; exp_q.size() > 0; cyc++) begin
            ov_t w;
            w = exp_q.pop_front();
            check(tag, cyc, obs2, w);
            if (do3 && q3.size() > 0) begin
                check({tag, "_r3main"}, cyc, obs3, w & ~REGM);
                check({tag, "_r3regs"}, cyc, ov_t'(regs3_obs), ov_t'(q3.pop_front()));
            end
            @(negedge clk);
        end
    endtask

    initial begin
        // ir=00 is LD r0<-[r0]; the 3-bit DUT runs LD RA=5 RB=3 alongside
        exp_fetch();
        exp_step(3, RE(4'b1000), MAR_S, '0);
        exp_step(4, RAM_E, RS(4'b1000), '0);
        exp_step(5, '0, '0, '0);
        for (int c = 0; c < 24; c++) begin
            logic [7:0] e3, s3;
            e3 = '0; s3 = '0;
            if (c >= 12 && c <= 14) e3 = 8'b00000100;
            if (c == 17)            s3 = 8'b00010000;
            q3.push_back({s3, e3});
        end
        run("ld00", 8'b0000_0000, 4'b0000, 1'b1);

        // ADD RA=1 RB=2
        exp_fetch();
        exp_step(3, RE(4'b0010), TMP_S, '0);
        exp_step(4, RE(4'b0100), ACC_S | FLG_S, CI | OP(3'b000));
        exp_step(5, ACC_E, RS(4'b0010), '0);
        run("add", 8'b1000_0110, 4'b0000, 1'b0);

        // CMP: no st5 strobes
        exp_fetch();
        exp_step(3, RE(4'b0010), TMP_S, '0);
        exp_step(4, RE(4'b0100), ACC_S | FLG_S, CI | OP(3'b111));
        exp_step(5, '0, '0, '0);
        run("cmp", 8'b1111_0110, 4'b0000, 1'b0);

        // JMPIF z taken
        exp_fetch();
        exp_step(3, IAR_E, MAR_S | ACC_S, BIT1);
        exp_step(4, ACC_E, IAR_S, '0);
        exp_step(5, RAM_E, IAR_S, '0);
        run("jmpif_t", 8'b0101_0001, 4'b0001, 1'b0);

        // JMPIF z not taken, other flags set
        exp_fetch();
        exp_step(3, IAR_E, MAR_S | ACC_S, BIT1);
        exp_step(4, ACC_E, IAR_S, '0);
        exp_step(5, '0, '0, '0);
        run("jmpif_n", 8'b0101_0001, 4'b1110, 1'b0);

        // DATA RB=3
        exp_fetch();
        exp_step(3, IAR_E, MAR_S | ACC_S, BIT1);
        exp_step(4, RAM_E, RS(4'b0001), '0);
        exp_step(5, ACC_E, IAR_S, '0);
        run("data", 8'b0010_0011, 4'b0000, 1'b0);

        // ST RA=2 RB=1
        exp_fetch();
        exp_step(3, RE(4'b0010), MAR_S, '0);
        exp_step(4, RE(4'b0100), RAM_S, '0);
        exp_step(5, '0, '0, '0);
        run("st", 8'b0001_1001, 4'b0000, 1'b0);

        // JMPR RB=2
        exp_fetch();
        exp_step(3, RE(4'b0010), IAR_S, '0);
        exp_step(4, '0, '0, '0);
        exp_step(5, '0, '0, '0);
        run("jmpr", 8'b0011_0010, 4'b0000, 1'b0);

        // JMP, then abandoned mid-st3 by the next reset
        exp_fetch();
        exp_step(3, IAR_E, MAR_S, '0);
        void'(exp_q.pop_back());
        void'(exp_q.pop_back());
        run("jmp_abort", 8'b0100_0000, 4'b0000, 1'b0);

        // CLF
        exp_fetch();
        exp_step(3, '0, FLG_S, BIT1);
        exp_step(4, '0, '0, '0);
        exp_step(5, '0, '0, '0);
        run("clf", 8'b0110_0000, 4'b0000, 1'b0);

        // 110 with operand 2: NOP
        exp_fetch();
        exp_step(3, '0, '0, '0);
        exp_step(4, '0, '0, '0);
        exp_step(5, '0, '0, '0);
        run("nop110", 8'b0110_0010, 4'b0000, 1'b0);

        // IO OUT RB=1, da=1
        exp_fetch();
`ifdef JCU_IO_EN
        exp_step(3, RE(4'b0100), IO_S, IO_IO | IO_DA);
        exp_step(4, '0, '0, IO_IO | IO_DA);
        exp_step(5, '0, '0, IO_IO | IO_DA);
`else
        exp_step(3, '0, '0, '0);
        exp_step(4, '0, '0, '0);
        exp_step(5, '0, '0, '0);
`endif
        run("io_out", 8'b0111_1101, 4'b0000, 1'b0);

        // IO IN RB=2, da=0
        exp_fetch();
`ifdef JCU_IO_EN
        exp_step(3, '0, '0, '0);
        exp_step(4, IO_E, RS(4'b0010), '0);
        exp_step(5, '0, '0, '0);
`else
        exp_step(3, '0, '0, '0);
        exp_step(4, '0, '0, '0);
        exp_step(5, '0, '0, '0);
`endif
        run("io_in", 8'b0111_0010, 4'b0000, 1'b0);

        // HALT: rises at cycle 20, then frozen for 100 cycles
        exp_fetch();
        exp_step(3, '0, '0, '0);
        exp_step(4, '0, '0, '0);
        exp_step(5, '0, '0, HALT);
        for (int c = 0; c < 100; c++) exp_q.push_back(HALT | ov_t'(6'b000001));
        run("halt", 8'b0110_0001, 4'b0000, 1'b0);

        // reset leaves halt and restarts at st0
        exp_step(0, IAR_E, MAR_S | ACC_S, BIT1);
        run("unhalt", 8'b0110_0001, 4'b0000, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
